// File: rtl/bcd_entry_pkg.sv
// ---------------------------------------------------------------------------
// bcd_entry_pkg
// Shared definitions for the BCD entry block: the entry/hold state encoding,
// the BCD digit width and the width of the committed binary value.
// ---------------------------------------------------------------------------
package bcd_entry_pkg;

  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 5;

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } digits_t;

endpackage

// File: rtl/bcd_entry_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One raw active-low pushbutton -> two-flop synchronizer -> level debouncer
// -> one-cycle press pulse on the debounced high-to-low transition.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_key_n  raw active-low key input (asynchronous to i_clk)
//   o_press  one-cycle pulse when the debounced level falls (press only)
// ---------------------------------------------------------------------------
module key_debounce
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  logic w_mismatch;
  logic w_accept;

  // The counter tracks how many consecutive synchronized samples have
  // disagreed with the debounced level; the sample that completes the run
  // is the one that flips the level.
  assign w_mismatch = r_sync2 ^ r_level;
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      // Only a 1 -> 0 acceptance is a press; releases are silent.
      r_press <= w_accept & r_level;
      if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/bcd_entry.sv
// ---------------------------------------------------------------------------
// bcd_entry
// Two-key decimal entry: "inc" steps a two-digit BCD entry (wrapping at
// MAX_VALUE), "enter" commits it as a binary value with a one-cycle valid.
// After a commit the block holds; the next inc restarts entry at 01.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   key_inc_n    raw active-low increment key
//   key_enter_n  raw active-low commit key
//   ones, tens   BCD digits of the current entry (to the 7-segment path)
//   value        binary value of the last committed entry
//   valid        one-cycle commit pulse
//   editing      high while in ENTRY
// ---------------------------------------------------------------------------
module bcd_entry
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_VALUE       = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_inc_n,
  input  logic               key_enter_n,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [VALUE_W-1:0] value,
  output logic               valid,
  output logic               editing
);

  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX_VALUE / 10);
  localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX_VALUE % 10);

  logic w_inc_ev;
  logic w_enter_ev;

  state_e             r_state;
  digits_t            r_digits;
  logic [VALUE_W-1:0] r_value;
  logic               r_valid;

  state_e             w_state_nx;
  digits_t            w_digits_nx;
  logic [VALUE_W-1:0] w_value_nx;
  logic               w_valid_nx;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_inc (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_inc_n),
    .o_press (w_inc_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_enter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_enter_n),
    .o_press (w_enter_ev)
  );

  // Decimal increment of the two-digit entry; the top value wraps to 00 so
  // the entry never exceeds MAX_VALUE and never leaves BCD.
  function automatic digits_t bcd_inc(input digits_t d);
    digits_t n;
    n = d;
    if ((d.tens == MAX_TENS) && (d.ones == MAX_ONES)) begin
      n.tens = '0;
      n.ones = '0;
    end else if (d.ones == DIGIT_W'(9)) begin
      n.ones = '0;
      n.tens = d.tens + 1'b1;
    end else begin
      n.ones = d.ones + 1'b1;
    end
    return n;
  endfunction

  // 10*tens + ones using shifts; the result always fits VALUE_W because the
  // entry is bounded by MAX_VALUE.
  function automatic logic [VALUE_W-1:0] digits_to_bin(input digits_t d);
    logic [VALUE_W-1:0] t8;
    logic [VALUE_W-1:0] t2;
    logic [VALUE_W-1:0] o1;
    t8 = VALUE_W'({d.tens, 3'b000});
    t2 = VALUE_W'({d.tens, 1'b0});
    o1 = VALUE_W'(d.ones);
    return t8 + t2 + o1;
  endfunction

  always_comb begin
    w_state_nx  = r_state;
    w_digits_nx = r_digits;
    w_value_nx  = r_value;
    w_valid_nx  = 1'b0;
    // Enter is tested first everywhere: a coincident inc is dropped.
    case (r_state)
      ST_ENTRY: begin
        if (w_enter_ev) begin
          w_value_nx = digits_to_bin(r_digits);
          w_valid_nx = 1'b1;
          w_state_nx = ST_HOLD;
        end else if (w_inc_ev) begin
          w_digits_nx = bcd_inc(r_digits);
        end
      end
      ST_HOLD: begin
        if (w_enter_ev) begin
          w_valid_nx = 1'b1;
        end else if (w_inc_ev) begin
          w_digits_nx.tens = '0;
          w_digits_nx.ones = DIGIT_W'(1);
          w_state_nx       = ST_ENTRY;
        end
      end
      default: begin
        w_state_nx = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ENTRY;
      r_digits <= '0;
      r_value  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_digits <= w_digits_nx;
      r_value  <= w_value_nx;
      r_valid  <= w_valid_nx;
    end
  end

  assign ones    = r_digits.ones;
  assign tens    = r_digits.tens;
  assign value   = r_value;
  assign valid   = r_valid;
  assign editing = (r_state == ST_ENTRY);

endmodule

// File: tb/tb_bcd_entry.sv
module tb_bcd_entry;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_inc_n = 1'b1;
  logic       key_enter_n = 1'b1;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [4:0] value;
  logic       valid;
  logic       editing;

  bcd_entry #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_VALUE      (31)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_inc_n   (key_inc_n),
    .key_enter_n (key_enter_n),
    .ones        (ones),
    .tens        (tens),
    .value       (value),
    .valid       (valid),
    .editing     (editing)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int m_val = 0;
  int m_value = 0;
  bit m_hold = 1'b0;
  int vcnt = 0;
  logic prev_v = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid pulse pops one expected value.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++;
      check_eq("valid_2cyc", prev_v, 0);
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("valid_value", value, exp_q.pop_front());
    end
    prev_v = valid;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: entry counter modulo 32, digits derived by division.
  task automatic press(input bit inc, input bit ent);
    if (ent) begin
      if (!m_hold) begin
        m_value = m_val;
        m_hold = 1'b1;
      end
      exp_q.push_back(m_value);
    end else if (inc) begin
      if (m_hold) begin
        m_val = 1;
        m_hold = 1'b0;
      end else begin
        m_val = (m_val + 1) % 32;
      end
    end
    if (inc) key_inc_n = 1'b0;
    if (ent) key_enter_n = 1'b0;
    hold(8);
    key_inc_n = 1'b1;
    key_enter_n = 1'b1;
    hold(8);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_tens"}, tens, m_val / 10);
    check_eq({tag, "_ones"}, ones, m_val % 10);
    check_eq({tag, "_editing"}, editing, !m_hold);
    check_eq({tag, "_value"}, value, m_value);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ones"}, ones, 0);
    check_eq({tag, "_tens"}, tens, 0);
    check_eq({tag, "_value"}, value, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_editing"}, editing, 1);
  endtask

  // Hold the current key state and wait (bounded) for the digits to move.
  task automatic wait_change(input string tag, input int limit);
    int t;
    bit changed;
    logic [7:0] snap;
    snap = {tens, ones};
    t = 0;
    changed = 1'b0;
    while (t < limit && !changed) begin
      @(negedge clk);
      t++;
      if ({tens, ones} !== snap) changed = 1'b1;
    end
    check_eq({tag, "_changed"}, changed, 1);
    check_eq({tag, "_lat_ge6"}, t >= 6, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #3;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    hold(2);

    repeat (12) press(1, 0);
    check_eq("r12_tens", tens, 1);
    check_eq("r12_ones", ones, 2);
    check_eq("r12_editing", editing, 1);
    check_eq("r12_no_valid", vcnt, 0);

    repeat (19) press(1, 0);
    check_model("at31");
    press(1, 0);
    check_model("wrap");
    repeat (23) press(1, 0);
    check_model("at23");
    press(0, 1);
    check_model("commit23");
    check_eq("commit23_vcnt", vcnt, 1);

    press(0, 1);
    check_model("rehold");
    check_eq("rehold_vcnt", vcnt, 2);
    press(1, 0);
    check_model("hold_inc");

    // Bouncing key: 2 low / 2 high for 20 cycles, then held low.
    repeat (5) begin
      key_inc_n = 1'b0;
      hold(2);
      key_inc_n = 1'b1;
      hold(2);
    end
    check_model("bounce_none");
    key_inc_n = 1'b0;
    wait_change("bounce", 20);
    hold(10);
    key_inc_n = 1'b1;
    hold(10);
    m_val = 2;
    check_model("bounce_one");

    repeat (3) press(1, 0);
    check_model("at05");
    press(1, 1);
    check_model("both");
    check_eq("both_vcnt", vcnt, 3);

    // Reset in the middle of a debounce with the key held.
    key_inc_n = 1'b0;
    hold(4);
    #2 rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    m_val = 0;
    m_value = 0;
    m_hold = 1'b0;
    wait_change("post_rst", 20);
    m_val = 1;
    check_model("post_rst");
    key_inc_n = 1'b1;
    hold(10);
    check_model("post_rst_rel");

    check_eq("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
